// File: rtl/tb_mmio_pkg.sv
// ----------------------------------------------------------------------------
// tb_mmio_pkg
// Shared definitions for the MMIO test-control slave: register byte offsets
// inside the 16-byte window, the exit FSM state type and the cycle counter
// width.
// ----------------------------------------------------------------------------
package tb_mmio_pkg;

    // Byte offsets after masking the address with 4'hC.
    localparam logic [3:0] OFS_EXIT     = 4'h0;
    localparam logic [3:0] OFS_PRINT    = 4'h4;
    localparam logic [3:0] OFS_CYCLE_HI = 4'h8;
    localparam logic [3:0] OFS_WDOG     = 4'hC;

    localparam int unsigned CNT_W = 64;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } mmio_state_e;

endpackage

// File: rtl/tb_mmio_ctrl_if.sv
// ----------------------------------------------------------------------------
// tb_mmio_ctrl_if
// OBI-style request/response bundle between the core data port (master) and
// the MMIO test-control slave.
//   req/gnt        request handshake, gnt is combinational in the slave
//   addr/we/be     byte address, write flag, byte enables
//   wdata          write data
//   rvalid/rdata   response, exactly one cycle after each grant
// ----------------------------------------------------------------------------
interface tb_mmio_ctrl_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/tb_mmio_char_fifo.sv
// ----------------------------------------------------------------------------
// tb_mmio_char_fifo
// Synchronous FIFO for console characters. No bypass: data pushed into an
// empty FIFO becomes visible on data_o one cycle later.
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i, data_i  push request and data (ignored while full)
//   pop_i           pop request (ignored while empty)
//   data_o          head entry, valid while !empty_o
//   full_o, empty_o status flags
//   level_o         number of stored entries, 0..DEPTH
// ----------------------------------------------------------------------------
module tb_mmio_char_fifo #(
    parameter int unsigned DEPTH = 16,  // power of two, >= 2
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic        do_push, do_pop;

    assign level_o = wptr_q - rptr_q;
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (level_o == (AW+1)'(DEPTH));
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // NOTE: storage has no reset; pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/tb_mmio_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mmio_ctrl
// MMIO test-control slave behind the core data port: exit/result register,
// buffered console, 64-bit cycle counter and inactivity watchdog.
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   bus                OBI-style slave port (req/gnt/addr/we/be/wdata/rvalid/rdata)
//   char_valid_o/char_o/char_ready_i   console byte stream (FIFO head)
//   exit_valid_o       sticky end-of-test, set once the console has drained
//   exit_code_o        code of the first EXIT write (0 = pass)
//   timeout_o          sticky watchdog flag
//   cycle_cnt_o        free-running cycle count
// Register map (addr & 4'hC): 0x0 EXIT, 0x4 PRINT, 0x8 CYCLE_HI, 0xC WDOG.
// ----------------------------------------------------------------------------
module tb_mmio_ctrl
    import tb_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] WDOG_RST   = 32'd0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    tb_mmio_ctrl_if.slave     bus,
    output logic              char_valid_o,
    output logic [7:0]        char_o,
    input  logic              char_ready_i,
    output logic              exit_valid_o,
    output logic [31:0]       exit_code_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  cycle_cnt_o
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    // ---------------- decode and handshake ----------------
    logic [31:0]      rel_addr;
    logic [3:0]       ofs;
    logic             print_wr, acc, push, pop;
    logic             fifo_full, fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic             unused_bits;

    // BASE_ADDR is 16-byte aligned, so only the low offset bits matter.
    assign rel_addr    = bus.addr - BASE_ADDR;
    assign ofs         = rel_addr[3:0] & 4'hC;
    assign unused_bits = ^{rel_addr[31:4], bus.be[3:1]};

    // A PRINT write into a full FIFO is held off so the core stalls.
    assign print_wr = bus.we && (ofs == OFS_PRINT);
    assign bus.gnt  = bus.req && !(print_wr && fifo_full);
    assign acc      = bus.gnt;
    assign push     = acc && print_wr && bus.be[0];
    assign pop      = char_valid_o && char_ready_i;

    tb_mmio_char_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (bus.wdata[7:0]),
        .pop_i   (pop),
        .data_o  (char_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign char_valid_o = !fifo_empty;

    // ---------------- registers ----------------
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      limit_q, limit_d;
    logic [31:0]      idle_q, idle_d;
    logic             timeout_q, timeout_d;
    logic [31:0]      exit_code_q, exit_code_d;
    mmio_state_e      state_q, state_d;

    // Response path, counters and watchdog.
    always_comb begin
        rvalid_d  = acc;
        rdata_d   = '0;
        hi_d      = hi_q;
        limit_d   = limit_q;
        cnt_d     = cnt_q + 1'b1;

        if (acc && !bus.we) begin
            case (ofs)
                OFS_EXIT: begin
                    rdata_d = cnt_q[31:0];
                    hi_d    = cnt_q[CNT_W-1:32];  // snapshot for a coherent 64-bit read
                end
                OFS_PRINT:    rdata_d = 32'(fifo_level);
                OFS_CYCLE_HI: rdata_d = hi_q;
                default:      rdata_d = limit_q;
            endcase
        end

        if (acc && bus.we && (ofs == OFS_WDOG)) limit_d = bus.wdata;

        // Any granted request (a WDOG write included) counts as activity.
        if (acc)              idle_d = '0;
        else if (&idle_q)     idle_d = idle_q;
        else                  idle_d = idle_q + 1'b1;

        timeout_d = timeout_q
                  || ((state_q != DONE) && (limit_q != '0) && (idle_d == limit_q));
    end

    // Exit FSM: the code latches on the first EXIT write; DONE waits until
    // the console is empty and no PRINT push is landing in the same cycle.
    always_comb begin
        state_d     = state_q;
        exit_code_d = exit_code_q;
        case (state_q)
            RUN: begin
                if (acc && bus.we && (ofs == OFS_EXIT)) begin
                    state_d     = DRAIN;
                    exit_code_d = bus.wdata;
                end
            end
            DRAIN:   if (fifo_empty && !push) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            hi_q        <= '0;
            limit_q     <= WDOG_RST;
            idle_q      <= '0;
            timeout_q   <= 1'b0;
            exit_code_q <= '0;
            state_q     <= RUN;
        end else begin
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            limit_q     <= limit_d;
            idle_q      <= idle_d;
            timeout_q   <= timeout_d;
            exit_code_q <= exit_code_d;
            state_q     <= state_d;
        end
    end

    assign bus.rvalid   = rvalid_q;
    assign bus.rdata    = rdata_q;
    assign exit_valid_o = (state_q == DONE);
    assign exit_code_o  = exit_code_q;
    assign timeout_o    = timeout_q;
    assign cycle_cnt_o  = cnt_q;

endmodule

// File: tb/tb_tb_mmio_ctrl.sv
// ----------------------------------------------------------------------------
// tb_tb_mmio_ctrl
// Self-checking bench for tb_mmio_ctrl. A behavioural model (byte queue,
// plain counters and flags) is stepped once per cycle on the falling edge;
// the same process compares every DUT output against it. Directed sequences
// add literal expectations for the scenarios of interest.
// ----------------------------------------------------------------------------
module tb_tb_mmio_ctrl;
    import tb_mmio_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        char_valid_o;
    logic [7:0]  char_o;
    logic        char_ready_i = 1'b0;
    logic        exit_valid_o;
    logic [31:0] exit_code_o;
    logic        timeout_o;
    logic [63:0] cycle_cnt_o;

    tb_mmio_ctrl_if bus ();

    tb_mmio_ctrl #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH),
        .WDOG_RST   (32'd0)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .bus          (bus),
        .char_valid_o (char_valid_o),
        .char_o       (char_o),
        .char_ready_i (char_ready_i),
        .exit_valid_o (exit_valid_o),
        .exit_code_o  (exit_code_o),
        .timeout_o    (timeout_o),
        .cycle_cnt_o  (cycle_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    byte unsigned m_q[$];
    logic [63:0]  m_cnt;
    logic [31:0]  m_hi, m_limit, m_idle, m_code, m_rdata;
    bit           m_rvalid, m_exiting, m_done, m_timeout;

    task automatic m_reset();
        m_q.delete();
        m_cnt = '0; m_hi = '0; m_limit = '0; m_idle = '0; m_code = '0; m_rdata = '0;
        m_rvalid = 0; m_exiting = 0; m_done = 0; m_timeout = 0;
    endtask

    function automatic bit m_gnt();
        logic [3:0] o;
        o = bus.addr[3:0] & 4'hC;
        return bus.req && !(bus.we && o == 4'h4 && m_q.size() == DEPTH);
    endfunction

    task automatic m_step();
        logic [3:0]  o;
        bit          acc, push, pop, done_pre;
        logic [31:0] lim_pre;
        o        = bus.addr[3:0] & 4'hC;
        acc      = m_gnt();
        push     = acc && bus.we && o == 4'h4 && bus.be[0];
        pop      = (m_q.size() != 0) && char_ready_i;
        done_pre = m_done;
        lim_pre  = m_limit;

        m_rvalid = acc;
        m_rdata  = '0;
        if (acc && !bus.we) begin
            case (o)
                4'h0: begin m_rdata = m_cnt[31:0]; m_hi = m_cnt[63:32]; end
                4'h4: m_rdata = m_q.size();
                4'h8: m_rdata = m_hi;
                default: m_rdata = m_limit;
            endcase
        end

        if (acc) m_idle = '0;
        else if (m_idle != 32'hFFFF_FFFF) m_idle++;
        if (!done_pre && lim_pre != 0 && m_idle == lim_pre) m_timeout = 1;
        if (acc && bus.we && o == 4'hC) m_limit = bus.wdata;

        if (m_exiting && !m_done && m_q.size() == 0 && !push) m_done = 1;
        else if (!m_exiting && acc && bus.we && o == 4'h0) begin
            m_exiting = 1;
            m_code    = bus.wdata;
        end

        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back(bus.wdata[7:0]);
        m_cnt++;
    endtask

    // Compare process: outputs against model every cycle, then advance model.
    always @(negedge clk_i) begin
        if (!rst_ni) m_reset();
        check("gnt", bus.gnt, m_gnt());
        check("rvalid", bus.rvalid, m_rvalid);
        if (m_rvalid) check("rdata", bus.rdata, m_rdata);
        check("char_valid", char_valid_o, m_q.size() != 0);
        if (m_q.size() != 0) check("char_o", char_o, m_q[0]);
        check("exit_valid", exit_valid_o, m_done);
        check("exit_code", exit_code_o, m_code);
        check("timeout", timeout_o, m_timeout);
        check("cycle_cnt", cycle_cnt_o, m_cnt);
        if (rst_ni) m_step();
    end

    // Console log of popped bytes.
    byte unsigned con_log[$];
    always @(negedge clk_i) begin
        if (rst_ni && char_valid_o && char_ready_i) con_log.push_back(char_o);
    end

    // char_ready driver: 0 = low, 1 = high, 2 = random each cycle.
    int ready_mode = 0;
    always @(posedge clk_i) begin
        #2;
        if (ready_mode == 2) char_ready_i = 1'($urandom_range(0, 1));
        else                 char_ready_i = (ready_mode == 1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic xfer(input logic we, input logic [3:0] ofs, input logic [3:0] be,
                        input logic [31:0] wdata, output logic [31:0] rdata);
        int n;
        bit g;
        n = 0;
        g = 0;
        @(posedge clk_i); #1;
        bus.req   = 1'b1;
        bus.we    = we;
        bus.addr  = BASE | ($urandom & 32'h0FFF_FFF0) | {28'h0, ofs} | ($urandom & 32'h3);
        bus.be    = be;
        bus.wdata = wdata;
        while (!g && n < 64) begin
            @(negedge clk_i);
            g = bus.gnt;
            n++;
            @(posedge clk_i); #1;
        end
        bus.req = 1'b0;
        bus.we  = 1'b0;
        check("xfer_granted", g, 1);
        @(negedge clk_i);
        rdata = bus.rdata;
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        repeat (cycles) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        while (char_valid_o && n < 200) begin @(negedge clk_i); n++; end
        check("drain_bound", char_valid_o, 0);
    endtask

    // Global time bound.
    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] rd;
        int          n;
        byte unsigned msg[3];

        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.be = '0; bus.wdata = '0;
        msg[0] = 8'h4F; msg[1] = 8'h4B; msg[2] = 8'h0A;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        check("reset_cnt", cycle_cnt_o, 0);
        check("reset_exit", exit_valid_o, 0);

        // 1: cycle counter read at cycle 100, then the HI shadow.
        while (m_cnt != 64'd99) begin @(posedge clk_i); #1; end
        xfer(1'b0, OFS_EXIT, 4'hF, 32'h0, rd);
        check("cnt_lo_at_100", rd, 32'd100);
        xfer(1'b0, OFS_CYCLE_HI, 4'hF, 32'h0, rd);
        check("cnt_hi", rd, 32'd0);

        // 2: console "OK\n".
        ready_mode = 1;
        con_log.delete();
        for (int i = 0; i < 3; i++) xfer(1'b1, OFS_PRINT, 4'h1, {24'h0, msg[i]}, rd);
        repeat (4) @(negedge clk_i);
        check("con_len", con_log.size(), 3);
        for (int i = 0; i < 3; i++) check("con_byte", con_log[i], msg[i]);

        // 3: fill the FIFO, 17th write stalls until one pop.
        ready_mode = 0;
        for (int i = 0; i < 16; i++) xfer(1'b1, OFS_PRINT, 4'h1, 32'h41 + i, rd);
        @(posedge clk_i); #1;
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = BASE | 32'h4; bus.be = 4'h1; bus.wdata = 32'h51;
        @(negedge clk_i);
        check("gnt_full", bus.gnt, 0);
        @(posedge clk_i); #1;
        ready_mode = 1;
        @(negedge clk_i);
        check("gnt_full_popping", bus.gnt, 0);
        @(posedge clk_i); #1;
        ready_mode = 0;
        @(negedge clk_i);
        check("gnt_after_pop", bus.gnt, 1);
        @(posedge clk_i); #1;
        bus.req = 1'b0; bus.we = 1'b0;
        xfer(1'b0, OFS_PRINT, 4'hF, 32'h0, rd);
        check("level_full", rd, 32'd16);
        ready_mode = 1;
        wait_drained();

        // Random phase (no EXIT writes).
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind <= 4)
                xfer(1'b1, OFS_PRINT, 4'($urandom_range(0, 15)), $urandom, rd);
            else if (kind <= 7)
                xfer(1'b0, 4'($urandom_range(0, 3) * 4), 4'hF, 32'h0, rd);
            else if (kind == 8)
                xfer(1'b1, OFS_WDOG, 4'hF, ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(5, 60)), rd);
            else
                xfer(1'b1, OFS_CYCLE_HI, 4'hF, $urandom, rd);
            repeat ($urandom_range(0, 3)) @(posedge clk_i);
        end
        ready_mode = 1;
        wait_drained();
        do_reset(1);

        // 5: watchdog fires 50 cycles after the WDOG grant, and is sticky.
        xfer(1'b1, OFS_WDOG, 4'hF, 32'd50, rd);
        n = 1;
        while (!timeout_o && n < 200) begin @(negedge clk_i); n++; end
        check("wdog_latency", n, 51);
        xfer(1'b0, OFS_WDOG, 4'hF, 32'h0, rd);
        check("wdog_readback", rd, 32'd50);
        check("timeout_sticky", timeout_o, 1);
        do_reset(1);
        xfer(1'b1, OFS_WDOG, 4'hF, 32'd0, rd);
        repeat (10000) @(posedge clk_i);
        @(negedge clk_i);
        check("wdog_disabled", timeout_o, 0);

        // 4: exit waits for the console to drain; later EXIT writes ignored.
        ready_mode = 0;
        for (int i = 0; i < 3; i++) xfer(1'b1, OFS_PRINT, 4'h1, 32'h61 + i, rd);
        xfer(1'b1, OFS_EXIT, 4'hF, 32'h1, rd);
        check("exit_code_now", exit_code_o, 32'h1);
        repeat (5) @(negedge clk_i);
        check("exit_waits", exit_valid_o, 0);
        @(posedge clk_i); #1;
        ready_mode = 1;
        n = 0;
        while (char_valid_o && n < 50) begin @(negedge clk_i); n++; end
        check("drain_empty_not_done", exit_valid_o, 0);
        @(negedge clk_i);
        check("exit_valid_after_drain", exit_valid_o, 1);
        xfer(1'b1, OFS_EXIT, 4'hF, 32'h0, rd);
        check("exit_code_kept", exit_code_o, 32'h1);

        // 6: reset while draining with 5 queued characters.
        do_reset(1);
        ready_mode = 0;
        for (int i = 0; i < 5; i++) xfer(1'b1, OFS_PRINT, 4'h1, 32'h30 + i, rd);
        xfer(1'b1, OFS_EXIT, 4'hF, 32'h7, rd);
        check("drain_code", exit_code_o, 32'h7);
        do_reset(1);
        @(negedge clk_i);
        check("rst_char_valid", char_valid_o, 0);
        check("rst_exit_code", exit_code_o, 0);
        check("rst_exit_valid", exit_valid_o, 0);
        check("rst_cnt", cycle_cnt_o, 0);
        check("rst_rvalid", bus.rvalid, 0);
        xfer(1'b0, OFS_PRINT, 4'hF, 32'h0, rd);
        check("rst_level", rd, 32'd0);
        xfer(1'b1, OFS_EXIT, 4'hF, 32'h3, rd);
        check("exit_again_code", exit_code_o, 32'h3);
        @(negedge clk_i);
        check("exit_again_done", exit_valid_o, 1);

        repeat (3) @(negedge clk_i);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
